// File: rtl/sopc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sopc_mem_arbiter
//
// Lets several bus masters share one fixed-latency synchronous memory port.
// Master 0 is the CPU data port and master 1 is the instruction-fetch port.
// Any further indices are extra bus masters. This lets the SOPC use a single
// unified instruction/data RAM.
//
// Only one access is in flight at a time. A transaction walks
// IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
//
// Handshake semantics:
//   * A master raises m_req[i] together with m_we/m_addr/m_wdata/m_sel and
//     holds them until it sees m_gnt[i]. m_gnt is one-hot, lasts exactly
//     one cycle, and can only appear in IDLE. The request fields are
//     captured on the edge that ends the grant cycle.
//   * A request withdrawn before it is granted has no effect.
//   * m_rvalid[i] pulses for one cycle when the granted access finishes.
//     For a read, m_rdata is valid in that cycle. For a write, the pulse is
//     the write acknowledge.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-low reset
//   m_req/m_we     per-master request and write enable
//   m_addr/m_wdata per-master address and write data (master i at slice i)
//   m_sel          per-master byte enables
//   m_gnt          one-hot grant (IDLE only)
//   m_rvalid       one-hot completion strobe
//   m_rdata        shared read data, holds its last captured read value
//   mem_*          shared memory port (mem_ce strobes for one cycle)
//   mem_rdata      memory read data, valid MEM_LATENCY cycles after mem_ce
//   dbg_state      current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
// ---------------------------------------------------------------------------
module sopc_mem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_MASTERS = 2,
   parameter int MEM_LATENCY = 1,
   parameter int RR_MODE     = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_MASTERS-1:0]              m_req,
   input  logic [NUM_MASTERS-1:0]              m_we,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel,
   output logic [NUM_MASTERS-1:0]              m_gnt,
   output logic [NUM_MASTERS-1:0]              m_rvalid,
   output logic [DATA_WIDTH-1:0]               m_rdata,
   output logic                                mem_ce,
   output logic                                mem_we,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   output logic [DATA_WIDTH-1:0]               mem_wdata,
   output logic [DATA_WIDTH/8-1:0]             mem_sel,
   input  logic [DATA_WIDTH-1:0]               mem_rdata,
   output logic [1:0]                          dbg_state
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   // Master 0 must have first priority after reset, so the round-robin
   // pointer starts on the last index.
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);
   localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SW-1:0]         sel_q, sel_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [IW-1:0]         last_winner_q, last_winner_d;

   // ------------------------------------------------------------------
   // Winner selection.
   // Both modes scan the masters in order from a start index.
   // Fixed priority starts at 0. Round-robin starts at last_winner+1 and
   // wraps from the top index back to 0.
   // ------------------------------------------------------------------
   logic          win_found;
   logic [IW-1:0] win_idx;
   int            cand;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (RR_MODE != 0) begin
            cand = (int'(last_winner_q) + 1 + k) % NUM_MASTERS;
         end else begin
            cand = k;
         end
         if (!win_found && m_req[cand]) begin
            win_found = 1'b1;
            win_idx   = IW'(cand);
         end
      end
   end

   // A grant is only meaningful in IDLE. The grant is also held off while
   // reset is asserted: the FSM sits in IDLE during reset, and this keeps
   // m_gnt at zero even if masters are requesting.
   logic grant_ok;
   assign grant_ok = rst && (state_q == ST_IDLE) && win_found;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      sel_d         = sel_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      last_winner_d = last_winner_q;

      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d       = ST_ISSUE;
               owner_d       = win_idx;
               we_d          = m_we[win_idx];
               addr_d        = m_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d       = m_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
               sel_d         = m_sel[win_idx*SW +: SW];
               last_winner_d = win_idx;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = LAT_LOAD;
            end
         end
         ST_WAIT: begin
            // The counter reaches zero in the cycle where mem_rdata is valid.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               rdata_d = mem_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         owner_q       <= '0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         sel_q         <= '0;
         cnt_q         <= '0;
         rdata_q       <= '0;
         last_winner_q <= LAST_RST;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         sel_q         <= sel_d;
         cnt_q         <= cnt_d;
         rdata_q       <= rdata_d;
         last_winner_q <= last_winner_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // All outputs come from reset flops or from gating with rst. An
   // asynchronous reset therefore clears them without waiting for a clock
   // edge.
   // ------------------------------------------------------------------
   always_comb begin
      m_gnt    = '0;
      m_rvalid = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_gnt[i]    = grant_ok && (win_idx == IW'(i));
         m_rvalid[i] = (state_q == ST_RESP) && (owner_q == IW'(i));
      end
   end

   // mem_addr and mem_wdata keep the captured values outside ISSUE.
   // mem_we and mem_sel are forced low outside ISSUE.
   assign mem_ce    = (state_q == ST_ISSUE);
   assign mem_we    = (state_q == ST_ISSUE) && we_q;
   assign mem_sel   = (state_q == ST_ISSUE) ? sel_q : '0;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign m_rdata   = rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sopc_mem_arbiter
//
// Three arbiter instances share one clock and reset:
//   dut_a : 2 masters, MEM_LATENCY=1, fixed priority
//   dut_b : 2 masters, MEM_LATENCY=3, fixed priority
//   dut_c : 3 masters, MEM_LATENCY=4, round-robin
//
// Each instance has a byte-masked memory model. The model presents read
// data only in the single cycle where it is due, and a poison value in
// every other cycle.
// ---------------------------------------------------------------------------
module tb_sopc_mem_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- dut_a signals ----------------
   logic [1:0]  req_a = '0, we_a = '0, gnt_a, rv_a;
   logic [63:0] addr_a = '0, wdata_a = '0;
   logic [7:0]  sel_a = '0;
   logic [31:0] rdata_a, maddr_a, mwd_a, mrd_a;
   logic        mce_a, mwe_a;
   logic [3:0]  msel_a;
   logic [1:0]  dbg_a;

   // ---------------- dut_b signals ----------------
   logic [1:0]  req_b = '0, we_b = '0, gnt_b, rv_b;
   logic [63:0] addr_b = '0, wdata_b = '0;
   logic [7:0]  sel_b = '0;
   logic [31:0] rdata_b, maddr_b, mwd_b, mrd_b;
   logic        mce_b, mwe_b;
   logic [3:0]  msel_b;
   logic [1:0]  dbg_b;

   // ---------------- dut_c signals ----------------
   logic [2:0]  req_c = '0, we_c = '0, gnt_c, rv_c;
   logic [95:0] addr_c = '0, wdata_c = '0;
   logic [11:0] sel_c = '0;
   logic [31:0] rdata_c, maddr_c, mwd_c, mrd_c;
   logic        mce_c, mwe_c;
   logic [3:0]  msel_c;
   logic [1:0]  dbg_c;

   sopc_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(2),
                      .MEM_LATENCY(1), .RR_MODE(0)) u_dut_a (
      .clk(clk), .rst(rst), .m_req(req_a), .m_we(we_a), .m_addr(addr_a),
      .m_wdata(wdata_a), .m_sel(sel_a), .m_gnt(gnt_a), .m_rvalid(rv_a),
      .m_rdata(rdata_a), .mem_ce(mce_a), .mem_we(mwe_a), .mem_addr(maddr_a),
      .mem_wdata(mwd_a), .mem_sel(msel_a), .mem_rdata(mrd_a), .dbg_state(dbg_a));

   sopc_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(2),
                      .MEM_LATENCY(3), .RR_MODE(0)) u_dut_b (
      .clk(clk), .rst(rst), .m_req(req_b), .m_we(we_b), .m_addr(addr_b),
      .m_wdata(wdata_b), .m_sel(sel_b), .m_gnt(gnt_b), .m_rvalid(rv_b),
      .m_rdata(rdata_b), .mem_ce(mce_b), .mem_we(mwe_b), .mem_addr(maddr_b),
      .mem_wdata(mwd_b), .mem_sel(msel_b), .mem_rdata(mrd_b), .dbg_state(dbg_b));

   sopc_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_MASTERS(3),
                      .MEM_LATENCY(4), .RR_MODE(1)) u_dut_c (
      .clk(clk), .rst(rst), .m_req(req_c), .m_we(we_c), .m_addr(addr_c),
      .m_wdata(wdata_c), .m_sel(sel_c), .m_gnt(gnt_c), .m_rvalid(rv_c),
      .m_rdata(rdata_c), .mem_ce(mce_c), .mem_we(mwe_c), .mem_addr(maddr_c),
      .mem_wdata(mwd_c), .mem_sel(msel_c), .mem_rdata(mrd_c), .dbg_state(dbg_c));

   // ---------------- memory models ----------------
   localparam logic [31:0] POISON = 32'hBAD0_BAD0;

   logic [31:0] mem_a [0:63];
   logic [32:0] dly_a [0:0];
   always @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < 64; j++) mem_a[j] <= '0;
         mem_a[4] <= 32'hDEAD_BEEF;
         mem_a[5] <= 32'hCAFE_0001;
         dly_a[0] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (mce_a && mwe_a && msel_a[b]) mem_a[maddr_a[7:2]][8*b +: 8] <= mwd_a[8*b +: 8];
         dly_a[0] <= {mce_a && !mwe_a, mem_a[maddr_a[7:2]]};
      end
   end
   assign mrd_a = dly_a[0][32] ? dly_a[0][31:0] : POISON;

   logic [31:0] mem_b [0:63];
   logic [32:0] dly_b [0:2];
   always @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < 64; j++) mem_b[j] <= '0;
         for (int s = 0; s < 3; s++) dly_b[s] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (mce_b && mwe_b && msel_b[b]) mem_b[maddr_b[7:2]][8*b +: 8] <= mwd_b[8*b +: 8];
         dly_b[0] <= {mce_b && !mwe_b, mem_b[maddr_b[7:2]]};
         for (int s = 1; s < 3; s++) dly_b[s] <= dly_b[s-1];
      end
   end
   assign mrd_b = dly_b[2][32] ? dly_b[2][31:0] : POISON;

   logic [31:0] mem_c [0:63];
   logic [32:0] dly_c [0:3];
   always @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < 64; j++) mem_c[j] <= '0;
         mem_c[16] <= 32'hC0DE_0000;
         mem_c[17] <= 32'hC0DE_0001;
         mem_c[18] <= 32'hC0DE_0002;
         for (int s = 0; s < 4; s++) dly_c[s] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (mce_c && mwe_c && msel_c[b]) mem_c[maddr_c[7:2]][8*b +: 8] <= mwd_c[8*b +: 8];
         dly_c[0] <= {mce_c && !mwe_c, mem_c[maddr_c[7:2]]};
         for (int s = 1; s < 4; s++) dly_c[s] <= dly_c[s-1];
      end
   end
   assign mrd_c = dly_c[3][32] ? dly_c[3][31:0] : POISON;

   // ---------------- scoreboard counters / check ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge. Callers drive inputs,
   // wait #1, then sample.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vectors ----------------
   initial begin
      int g;

      // Reset state. Requests are held high to show that no grant leaks
      // out while reset is asserted.
      req_a = 2'b11;
      repeat (3) tick();
      #1;
      chk("rst_gnt_a",   32'(gnt_a),   32'h0);
      chk("rst_rv_a",    32'(rv_a),    32'h0);
      chk("rst_rdata_a", rdata_a,      32'h0);
      chk("rst_mce_a",   32'(mce_a),   32'h0);
      chk("rst_mwe_a",   32'(mwe_a),   32'h0);
      chk("rst_maddr_a", maddr_a,      32'h0);
      chk("rst_mwd_a",   mwd_a,        32'h0);
      chk("rst_msel_a",  32'(msel_a),  32'h0);
      chk("rst_dbg_a",   32'(dbg_a),   32'h0);
      chk("rst_dbg_c",   32'(dbg_c),   32'h0);
      req_a = 2'b00;
      tick();
      rst = 1'b1;
      tick();

      // ---- Single read, master 1, MEM_LATENCY=1 ----
      tick();
      req_a = 2'b10; we_a = 2'b00; addr_a[63:32] = 32'h10; sel_a = 8'hFF;
      #1;
      chk("rd1_gnt_T",    32'(gnt_a), 32'h2);
      chk("rd1_dbg_T",    32'(dbg_a), 32'h0);
      tick(); req_a = 2'b00; #1;
      chk("rd1_ce_T1",    32'(mce_a), 32'h1);
      chk("rd1_we_T1",    32'(mwe_a), 32'h0);
      chk("rd1_addr_T1",  maddr_a,    32'h10);
      chk("rd1_gnt_T1",   32'(gnt_a), 32'h0);
      tick(); #1;
      chk("rd1_ce_T2",    32'(mce_a), 32'h0);
      chk("rd1_rv_T2",    32'(rv_a),  32'h0);
      tick(); #1;
      chk("rd1_rv_T3",    32'(rv_a),  32'h2);
      chk("rd1_data_T3",  rdata_a,    32'hDEAD_BEEF);
      tick(); #1;
      chk("rd1_rv_T4",    32'(rv_a),  32'h0);
      chk("rd1_hold_T4",  rdata_a,    32'hDEAD_BEEF);

      // ---- Late request: master 1 asks during master 0's WAIT ----
      tick();
      req_a = 2'b01; addr_a[31:0] = 32'h14;
      #1;
      chk("late_gnt0_T",  32'(gnt_a), 32'h1);
      tick(); req_a = 2'b00; #1;
      chk("late_gnt_T1",  32'(gnt_a), 32'h0);
      tick(); req_a = 2'b10; addr_a[63:32] = 32'h10; #1;
      chk("late_dbg_T2",  32'(dbg_a), 32'h2);
      chk("late_gnt_T2",  32'(gnt_a), 32'h0);
      tick(); #1;
      chk("late_rv_T3",   32'(rv_a),  32'h1);
      chk("late_data_T3", rdata_a,    32'hCAFE_0001);
      chk("late_gnt_T3",  32'(gnt_a), 32'h0);
      tick(); #1;
      chk("late_gnt1_T4", 32'(gnt_a), 32'h2);
      tick(); req_a = 2'b00; #1;
      chk("late_addr_T5", maddr_a,    32'h10);
      tick(); #1;
      tick(); #1;
      chk("late_rv_T7",   32'(rv_a),  32'h2);
      chk("late_data_T7", rdata_a,    32'hDEAD_BEEF);

      // ---- Fixed priority: both masters request continuously ----
      addr_a = {32'h10, 32'h14};
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 0) req_a = 2'b11;
         #1;
         chk($sformatf("fp_gnt_%0d", i), 32'(gnt_a), (i % 4 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("fp_rv_%0d", i),  32'(rv_a),  (i % 4 == 3) ? 32'h1 : 32'h0);
      end
      tick(); req_a = 2'b00; #1;
      chk("fp_gnt_end", 32'(gnt_a), 32'h0);

      // ---- Write then read back, MEM_LATENCY=3, byte-masked ----
      tick();
      req_b = 2'b01; we_b = 2'b01; addr_b[31:0] = 32'h20;
      wdata_b[31:0] = 32'h1234_5678; sel_b[3:0] = 4'b0011;
      #1;
      chk("wr_gnt_T",     32'(gnt_b),  32'h1);
      tick(); req_b = 2'b00; #1;
      chk("wr_ce_T1",     32'(mce_b),  32'h1);
      chk("wr_we_T1",     32'(mwe_b),  32'h1);
      chk("wr_sel_T1",    32'(msel_b), 32'h3);
      chk("wr_addr_T1",   maddr_b,     32'h20);
      chk("wr_wdata_T1",  mwd_b,       32'h1234_5678);
      tick(); #1;
      chk("wr_ack_T2",    32'(rv_b),   32'h1);
      chk("wr_ce_T2",     32'(mce_b),  32'h0);
      chk("wr_we_T2",     32'(mwe_b),  32'h0);
      chk("wr_sel_T2",    32'(msel_b), 32'h0);
      chk("wr_addr_T2",   maddr_b,     32'h20);
      chk("wr_rdata_T2",  rdata_b,     32'h0);
      tick();
      req_b = 2'b01; we_b = 2'b00; sel_b[3:0] = 4'hF;
      #1;
      chk("rb_gnt_T",     32'(gnt_b),  32'h1);
      tick(); req_b = 2'b00; #1;
      chk("rb_ce_T1",     32'(mce_b),  32'h1);
      chk("rb_we_T1",     32'(mwe_b),  32'h0);
      chk("rb_sel_T1",    32'(msel_b), 32'hF);
      for (int i = 2; i <= 4; i++) begin
         tick(); #1;
         chk($sformatf("rb_rv_T%0d", i), 32'(rv_b), 32'h0);
      end
      tick(); #1;
      chk("rb_rv_T5",     32'(rv_b),   32'h1);
      chk("rb_data_T5",   rdata_b,     32'h0000_5678);

      // ---- Round-robin, 3 masters, MEM_LATENCY=4 (7 cycles/read) ----
      addr_c = {32'h48, 32'h44, 32'h40};
      sel_c  = 12'hFFF;
      for (int i = 0; i < 42; i++) begin
         tick();
         if (i == 0) req_c = 3'b111;
         #1;
         g = (i / 7) % 3;
         chk($sformatf("rr_gnt_%0d", i), 32'(gnt_c), (i % 7 == 0) ? 32'(1 << g) : 32'h0);
         chk($sformatf("rr_rv_%0d", i),  32'(rv_c),  (i % 7 == 6) ? 32'(1 << g) : 32'h0);
         if (i % 7 == 6) chk($sformatf("rr_data_%0d", i), rdata_c, 32'hC0DE_0000 + 32'(g));
      end
      tick(); req_c = 3'b000; #1;
      chk("rr_gnt_end", 32'(gnt_c), 32'h0);

      // ---- Asynchronous reset in the middle of WAIT ----
      tick(); req_c = 3'b010; #1;
      chk("ar_gnt_T",   32'(gnt_c), 32'h2);
      tick(); req_c = 3'b000; #1;
      chk("ar_ce_T1",   32'(mce_c), 32'h1);
      tick(); #1;
      chk("ar_dbg_T2",  32'(dbg_c), 32'h2);
      tick(); #1;
      chk("ar_dbg_T3",  32'(dbg_c), 32'h2);
      #1;
      rst = 1'b0;
      #1;
      // No clock edge since reset was asserted.
      chk("ar_dbg_now",   32'(dbg_c),  32'h0);
      chk("ar_ce_now",    32'(mce_c),  32'h0);
      chk("ar_addr_now",  maddr_c,     32'h0);
      chk("ar_sel_now",   32'(msel_c), 32'h0);
      chk("ar_rdata_now", rdata_c,     32'h0);
      chk("ar_rv_now",    32'(rv_c),   32'h0);
      chk("ar_addr_a",    maddr_a,     32'h0);
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         chk($sformatf("ar_no_rv_%0d", i), 32'(rv_c), 32'h0);
      end
      tick(); req_c = 3'b001; #1;
      chk("ar_regnt_T",   32'(gnt_c), 32'h1);
      tick(); req_c = 3'b000; #1;
      chk("ar_ce2_T1",    32'(mce_c), 32'h1);
      chk("ar_addr2_T1",  maddr_c,    32'h40);
      for (int i = 2; i <= 5; i++) begin
         tick(); #1;
         chk($sformatf("ar_rv2_T%0d", i), 32'(rv_c), 32'h0);
      end
      tick(); #1;
      chk("ar_rv2_T6",    32'(rv_c),  32'h1);
      chk("ar_data2_T6",  rdata_c,    32'hC0DE_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
